// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the pipeline entry type used by the
// single-master initiator and any slave reusing the alignment checker.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        bad;
    } entry_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus signals between the initiator and the decoder/response mux.
interface ahb_lite_master_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/ahb_lite_align_chk.sv
// Flags a transfer that cannot go on the bus: unsupported size or an
// address not aligned to its size. Only the two low address bits matter.
module ahb_lite_align_chk
    import ahb_lite_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] size,
    output logic       bad
);

    always_comb begin
        bad = 1'b1;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = addr[0];
            HSIZE_WORD: bad = |addr;
            default:    bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready commands become pipelined SINGLE transfers
// with one in-order response per command, including locally rejected ones.
module ahb_lite_master
    import ahb_lite_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [31:0]              cmd_addr,
    input  logic [2:0]               cmd_size,
    input  logic [31:0]              cmd_wdata,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    ahb_lite_master_if.master        bus
);

    entry_t      ap_p0;
    logic        dp_vld_p1;
    logic        dp_write_p1;
    logic        dp_bad_p1;
    logic [31:0] dp_wdata_p1;
    logic        cmd_bad;
    logic        accept;
    logic        complete;

    function automatic logic [31:0] rsp_data(input logic        write,
                                             input logic        bad,
                                             input logic        resp,
                                             input logic [31:0] rdata);
        return (!write && !bad && (resp == HRESP_OKAY)) ? rdata : 32'd0;
    endfunction

    ahb_lite_align_chk u_align_chk (
        .addr (cmd_addr[1:0]),
        .size (cmd_size),
        .bad  (cmd_bad)
    );

    assign cmd_ready = bus.HREADY;
    assign accept    = cmd_valid && bus.HREADY;
    assign complete  = bus.HREADY && dp_vld_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ap_p0       <= '0;
            dp_vld_p1   <= 1'b0;
            dp_write_p1 <= 1'b0;
            dp_bad_p1   <= 1'b0;
            dp_wdata_p1 <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            // response stage: data phase retires on HREADY
            rsp_valid <= complete;
            if (complete) begin
                rsp_err   <= dp_bad_p1 | (bus.HRESP == HRESP_ERROR);
                rsp_rdata <= rsp_data(dp_write_p1, dp_bad_p1, bus.HRESP, bus.HRDATA);
            end else begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end

            // address phase -> data phase
            if (bus.HREADY) begin
                dp_vld_p1   <= ap_p0.valid;
                dp_write_p1 <= ap_p0.write;
                dp_bad_p1   <= ap_p0.bad;
                dp_wdata_p1 <= ap_p0.wdata;
                if (accept) begin
                    ap_p0 <= '{valid: 1'b1, write: cmd_write, addr: cmd_addr,
                               size: cmd_size, wdata: cmd_wdata, bad: cmd_bad};
                end else begin
                    ap_p0.valid <= 1'b0;
                end
            end else if ((bus.HRESP == HRESP_ERROR) && dp_vld_p1 && ap_p0.valid) begin
                // first ERROR cycle: withdraw the pending address so E2 shows IDLE
                ap_p0.bad <= 1'b1;
            end
        end
    end

    assign bus.HTRANS    = (ap_p0.valid && !ap_p0.bad) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = ap_p0.addr;
    assign bus.HWRITE    = ap_p0.write;
    assign bus.HSIZE     = ap_p0.size;
    assign bus.HWDATA    = dp_wdata_p1;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_DEFAULT;
    assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed scenarios plus a randomized run against a queue-based model of
// command order, bus issue order and expected responses.
module tb_ahb_lite_master;
    import ahb_lite_pkg::*;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        bad;
    } cmd_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    ahb_lite_master_if bus ();

    ahb_lite_master dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = d;
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic is_bad(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b1;
        return (a % (32'd1 << s)) != 32'd0;
    endfunction

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_size = '0; cmd_wdata = '0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'hFFFF_FFFF;
        step(); step();
        checks++;
        if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'd0 || bus.HWRITE !== 1'b0 ||
            bus.HSIZE !== 3'd0 || bus.HWDATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: htrans=%h haddr=%h hwrite=%b hsize=%h hwdata=%h, expected all 0",
                     bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HWDATA);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b err=%b rdata=%h, expected 0", rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if (bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011 || bus.HMASTLOCK !== 1'b0) begin
            errors++;
            $display("FAIL reset_const: hburst=%h hprot=%h hmastlock=%b, expected 0/3/0",
                     bus.HBURST, bus.HPROT, bus.HMASTLOCK);
        end
        reset = 1'b0;
        bus.HREADY = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL ready_follows_hready: got %b expected 0", cmd_ready);
        end
        bus.HREADY = 1'b1;
        step();
    endtask

    task automatic test_write();
        put_cmd(1'b1, 32'h0000_1004, 3'd2, 32'hDEAD_BEEF);
        step();
        cmd_valid = 1'b0;
        checks++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h1004 || bus.HWRITE !== 1'b1 || bus.HSIZE !== 3'd2) begin
            errors++;
            $display("FAIL wr_addr_phase: htrans=%h haddr=%h hwrite=%b hsize=%h, expected 2/1004/1/2",
                     bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE);
        end
        step();
        checks++;
        if (bus.HWDATA !== 32'hDEAD_BEEF || bus.HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_data_phase: hwdata=%h htrans=%h rsp_valid=%b, expected deadbeef/0/0",
                     bus.HWDATA, bus.HTRANS, rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL wr_rsp: valid=%b err=%b rdata=%h, expected 1/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL wr_rsp_pulse: valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        put_cmd(1'b0, 32'h100, 3'd2, 32'd0);
        step();
        checks++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h100) begin
            errors++; $display("FAIL b2b_first: htrans=%h haddr=%h expected 2/100", bus.HTRANS, bus.HADDR);
        end
        put_cmd(1'b0, 32'h104, 3'd2, 32'd0);
        step();
        cmd_valid = 1'b0;
        checks++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h104) begin
            errors++; $display("FAIL b2b_second: htrans=%h haddr=%h expected 2/104", bus.HTRANS, bus.HADDR);
        end
        bus.HRDATA = 32'h11;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL b2b_rsp1: valid=%b rdata=%h err=%b expected 1/11/0", rsp_valid, rsp_rdata, rsp_err);
        end
        bus.HRDATA = 32'h22;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL b2b_rsp2: valid=%b rdata=%h err=%b expected 1/22/0", rsp_valid, rsp_rdata, rsp_err);
        end
        step();
    endtask

    task automatic test_wait_states();
        put_cmd(1'b0, 32'h200, 3'd2, 32'd0);
        step();
        put_cmd(1'b0, 32'h204, 3'd2, 32'd0);
        step();
        cmd_valid = 1'b0;
        bus.HREADY = 1'b0;
        bus.HRDATA = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h204 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold%0d: htrans=%h haddr=%h ready=%b rsp_valid=%b expected 2/204/0/0",
                         i, bus.HTRANS, bus.HADDR, cmd_ready, rsp_valid);
            end
            step();
        end
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h2222;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2222) begin
            errors++; $display("FAIL wait_rsp200: valid=%b rdata=%h expected 1/2222", rsp_valid, rsp_rdata);
        end
        bus.HRDATA = 32'h3333;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h3333) begin
            errors++; $display("FAIL wait_rsp204: valid=%b rdata=%h expected 1/3333", rsp_valid, rsp_rdata);
        end
        step();
    endtask

    task automatic test_error_cancel();
        bus.HRDATA = 32'hFFFF_FFFF;
        put_cmd(1'b0, 32'h300, 3'd2, 32'd0);
        step();
        put_cmd(1'b0, 32'h304, 3'd2, 32'd0);
        step();
        cmd_valid = 1'b0;
        bus.HRESP = 1'b1; bus.HREADY = 1'b0;
        step();
        bus.HREADY = 1'b1;
        #1;
        checks++;
        if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h304) begin
            errors++; $display("FAIL err_e2_idle: htrans=%h haddr=%h expected 0/304", bus.HTRANS, bus.HADDR);
        end
        step();
        bus.HRESP = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0 || bus.HTRANS !== 2'b00) begin
            errors++;
            $display("FAIL err_rsp300: valid=%b err=%b rdata=%h htrans=%h expected 1/1/0/0",
                     rsp_valid, rsp_err, rsp_rdata, bus.HTRANS);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL err_rsp304: valid=%b err=%b rdata=%h expected 1/1/0", rsp_valid, rsp_err, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL err_drain: valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_misaligned();
        put_cmd(1'b0, 32'h102, 3'd2, 32'd0);
        step();
        checks++;
        if (bus.HTRANS !== 2'b00) begin
            errors++; $display("FAIL mis_idle: htrans=%h expected 0", bus.HTRANS);
        end
        put_cmd(1'b0, 32'h103, 3'd0, 32'd0);
        step();
        cmd_valid = 1'b0;
        checks++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h103 || bus.HSIZE !== 3'd0) begin
            errors++;
            $display("FAIL mis_byte_issue: htrans=%h haddr=%h hsize=%h expected 2/103/0", bus.HTRANS, bus.HADDR, bus.HSIZE);
        end
        bus.HRDATA = 32'hAB;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL mis_rsp_bad: valid=%b err=%b rdata=%h expected 1/1/0", rsp_valid, rsp_err, rsp_rdata);
        end
        bus.HRDATA = 32'hCD;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCD) begin
            errors++; $display("FAIL mis_rsp_ok: valid=%b err=%b rdata=%h expected 1/0/cd", rsp_valid, rsp_err, rsp_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        put_cmd(1'b0, 32'h400, 3'd2, 32'd0);
        step();
        put_cmd(1'b1, 32'h404, 3'd2, 32'h5555_AAAA);
        step();
        cmd_valid = 1'b0;
        bus.HREADY = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.HREADY = 1'b1;
        checks++;
        if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'd0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: htrans=%h haddr=%h rsp_valid=%b expected 0/0/0", bus.HTRANS, bus.HADDR, rsp_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0 || bus.HTRANS !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_quiet%0d: rsp_valid=%b htrans=%h expected 0/0", i, rsp_valid, bus.HTRANS);
            end
        end
    endtask

    task automatic test_random();
        cmd_t        issueq[$];
        cmd_t        rspq[$];
        cmd_t        c;
        cmd_t        dp;
        logic        dp_act;
        logic        hr;
        logic [1:0]  ht;
        logic [31:0] a;
        logic [31:0] exp_rd;
        logic        drain;
        dp_act = 1'b0;
        dp = '{write: 1'b0, addr: 32'd0, size: 3'd0, wdata: 32'd0, bad: 1'b0};
        bus.HRESP = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rspq.size() == 0) begin
                    errors++; $display("FAIL rnd_rsp_extra: cycle %0d unexpected response", cyc);
                end else begin
                    c = rspq.pop_front();
                    exp_rd = (c.bad || c.write) ? 32'd0 : rd_of(c.addr);
                    if (rsp_err !== c.bad || rsp_rdata !== exp_rd) begin
                        errors++;
                        $display("FAIL rnd_rsp: addr=%h err=%b rdata=%h expected err=%b rdata=%h",
                                 c.addr, rsp_err, rsp_rdata, c.bad, exp_rd);
                    end
                end
            end
            ht = bus.HTRANS;
            if (ht == 2'b10) begin
                checks++;
                if (issueq.size() == 0) begin
                    errors++; $display("FAIL rnd_issue_extra: NONSEQ haddr=%h with nothing pending", bus.HADDR);
                end else if (bus.HADDR !== issueq[0].addr || bus.HWRITE !== issueq[0].write ||
                             bus.HSIZE !== issueq[0].size) begin
                    errors++;
                    $display("FAIL rnd_issue: haddr=%h hwrite=%b hsize=%h expected %h/%b/%h", bus.HADDR,
                             bus.HWRITE, bus.HSIZE, issueq[0].addr, issueq[0].write, issueq[0].size);
                end
            end
            if (dp_act && dp.write) begin
                checks++;
                if (bus.HWDATA !== dp.wdata) begin
                    errors++; $display("FAIL rnd_hwdata: got %h expected %h", bus.HWDATA, dp.wdata);
                end
            end
            drain = (cyc >= 560);
            hr = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.HREADY = hr;
            bus.HRDATA = dp_act ? rd_of(dp.addr) : $urandom;
            cmd_valid = !drain && ($urandom_range(0, 2) != 0);
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & ~32'h3;
            cmd_addr  = a;
            cmd_size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            cmd_write = $urandom_range(0, 1) != 0;
            cmd_wdata = $urandom;
            if (hr) begin
                if (ht == 2'b10 && issueq.size() != 0) begin
                    dp = issueq.pop_front();
                    dp_act = 1'b1;
                end else begin
                    dp_act = 1'b0;
                end
                if (cmd_valid) begin
                    c = '{write: cmd_write, addr: cmd_addr, size: cmd_size, wdata: cmd_wdata,
                          bad: is_bad(cmd_addr, cmd_size)};
                    rspq.push_back(c);
                    if (!c.bad) issueq.push_back(c);
                end
            end
            step();
        end
        checks++;
        if (rspq.size() != 0 || issueq.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: %0d responses and %0d issues outstanding, expected 0",
                     rspq.size(), issueq.size());
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_wait_states();
        test_error_cancel();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
